sample_player: RTL
==================

Name: sample_player

Overview:
Parametrised successor to the free-running ROM-to-PDM audio path. It plays an address range of an external sample ROM at a programmable sample period, in one-shot or loop mode, with per-play gain. It drives the audio PMOD PDM pin through an internal first-order sigma-delta modulator. It sits between the top-level tile wrapper (config and ROM) and the `uio_out[7]` audio pin.

Parameters:
ADDR_W, 7, ROM address width (depth = 2^ADDR_W)
DATA_W, 8, ROM sample width (unsigned)
GAIN_W, 4, gain multiplier width (unsigned, 0..2^GAIN_W-1)
DIV_W, 8, sample-period divider width
PDM_W, 16, modulator input width; must be >= DATA_W+GAIN_W

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin playback
stop  in  1  single-cycle pulse: abort playback
cfg_start  in  ADDR_W  first sample address
cfg_end  in  ADDR_W  last sample address (inclusive)
cfg_div  in  DIV_W  hold length; sample period = cfg_div+3 clocks
cfg_loop  in  1  1 = restart at cfg_start after cfg_end
cfg_gain  in  GAIN_W  sample multiplier
rom_addr  out  ADDR_W  ROM read address (registered)
rom_data  in  DATA_W  ROM data, valid exactly 1 clock after rom_addr
busy  out  1  playback active
done  out  1  1-cycle pulse at end of one-shot playback
sample_out  out  DATA_W+GAIN_W  current scaled sample
sample_valid  out  1  1-cycle pulse when sample_out updates
pdm_out  out  1  PDM bitstream

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; busy, done, sample_valid, pdm_out = 0; sample_out = 0; rom_addr = 0; modulator accumulator = 0; config snapshot = 0.
- FSM states:
  - IDLE: busy=0. On start (and not stop): snapshot cfg_* into internal registers; rom_addr<=cfg_start; go to REQ. Config inputs are ignored after the snapshot until the next start.
  - REQ (1 clk): rom_addr is stable; go to LATCH.
  - LATCH (1 clk): sample_out <= rom_data*gain, full-width unsigned product, no truncation. Assert sample_valid for this cycle. Load hold counter with div. Go to HOLD.
  - HOLD: decrement the counter each clock; leave when it reads 0, giving div+1 cycles.
    - On leaving with rom_addr != end: rom_addr <= rom_addr+1 mod 2^ADDR_W; go to REQ.
    - On leaving with rom_addr == end and loop=1: rom_addr <= start; go to REQ.
    - On leaving with rom_addr == end and loop=0: done=1 for 1 clk; go to IDLE. sample_out holds its last value.
- busy=1 in REQ, LATCH and HOLD.
- Latency: first sample_valid occurs 2 clks after the start cycle. Consecutive sample_valid pulses are exactly div+3 clks apart. Loop restart uses the same spacing, with no gap.
- Wrap-around: cfg_start > cfg_end plays start..2^ADDR_W-1, then 0..end. start == end plays a single sample.
- stop in any state: next state IDLE; sample_out <= 0; no done pulse; rom_addr holds its value.
- start and stop in the same cycle: stop wins.
- start while busy: ignored.
- gain=0: playback runs normally with sample_out=0.
- Modulator:
  - pdm_in = sample_out zero-extended to PDM_W.
  - Each clock: acc(PDM_W+1 bits) <= {1'b0, acc[PDM_W-1:0]} + pdm_in; pdm_out = acc[PDM_W] (registered).
  - Ones density = pdm_in/2^PDM_W.
  - The modulator runs continuously, including in IDLE.

Decomposition:
- Package sample_player_pkg: state enum (IDLE, REQ, LATCH, HOLD) and default width localparams.
- One sub-module: pdm_modulator (parameter PDM_W; ports clk, rst_n, pdm_in, pdm_out) with the same async reset.
- The FSM, counter and gain multiply stay in sample_player.
- The ROM stays outside the block.

Test Plan:
- One-shot: ROM[a]=a+0x10, start=2, end=4, div=1, gain=1, loop=0.
  - Expect sample_out 0x12, 0x13, 0x14 with sample_valid 4 clks apart.
  - Expect done 1 pulse 2 clks after the last sample_valid, then busy=0.
- Loop + wrap: start=126, end=1, div=0, loop=1.
  - Expect address sequence 126, 127, 0, 1, 126, … with sample_valid every 3 clks.
  - Expect done never asserted.
- Gain/width: ROM data 0xFF, gain=15.
  - Expect sample_out=3825 (0xEF1).
  - Over 65536 clks, expect pdm_out ones count = 3825 ±1.
  - gain=0 gives pdm_out constant 0.
- Stop mid-play, plus start/stop collision:
  - stop during HOLD: busy=0 next clk, sample_out=0, no done.
  - start+stop in the same IDLE cycle: stays IDLE.
- Start while busy: a second start during playback does not restart it and does not change the address sequence or cfg snapshot.
- Async reset mid-HOLD: rst_n low between clock edges → all outputs 0 immediately. After release, the block stays IDLE until start.

Source files
------------

// File: rtl/sample_player_pkg.sv
// Shared types and default widths for the sample player and its bus interface.
package sample_player_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LATCH,
    HOLD
  } state_t;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_GAIN_W = 4;
  localparam int unsigned DEF_DIV_W  = 8;
  localparam int unsigned DEF_PDM_W  = 16;

endpackage

// File: rtl/sample_player_if.sv
// Control, config, ROM and status signals between the tile wrapper (master) and the player (slave).
interface sample_player_if
  import sample_player_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned GAIN_W = DEF_GAIN_W,
  parameter int unsigned DIV_W  = DEF_DIV_W
) ();

  logic                       start;
  logic                       stop;
  logic [ADDR_W-1:0]          cfg_start;
  logic [ADDR_W-1:0]          cfg_end;
  logic [DIV_W-1:0]           cfg_div;
  logic                       cfg_loop;
  logic [GAIN_W-1:0]          cfg_gain;
  logic [ADDR_W-1:0]          rom_addr;
  logic [DATA_W-1:0]          rom_data;
  logic                       busy;
  logic                       done;
  logic [DATA_W+GAIN_W-1:0]   sample_out;
  logic                       sample_valid;

  modport master (
    output start, stop, cfg_start, cfg_end, cfg_div, cfg_loop, cfg_gain, rom_data,
    input  rom_addr, busy, done, sample_out, sample_valid
  );

  modport slave (
    input  start, stop, cfg_start, cfg_end, cfg_div, cfg_loop, cfg_gain, rom_data,
    output rom_addr, busy, done, sample_out, sample_valid
  );

endinterface

// File: rtl/pdm_modulator.sv
// First-order sigma-delta modulator: the carry out of a running sum is the PDM bit.
module pdm_modulator #(
  parameter int unsigned PDM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PDM_W-1:0] pdm_in,
  output logic             pdm_out
);

  logic [PDM_W:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      acc <= {1'b0, acc[PDM_W-1:0]} + {1'b0, pdm_in};
    end
  end

  assign pdm_out = acc[PDM_W];

endmodule

// File: rtl/sample_player.sv
// Plays a ROM address range at a programmable period with gain, feeding a PDM modulator.
module sample_player
  import sample_player_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned GAIN_W = DEF_GAIN_W,
  parameter int unsigned DIV_W  = DEF_DIV_W,
  parameter int unsigned PDM_W  = DEF_PDM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  sample_player_if.slave   bus,
  output logic             pdm_out
);

  localparam int unsigned SAMP_W = DATA_W + GAIN_W;

  state_t              state;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [ADDR_W-1:0]   start_r;
  logic [ADDR_W-1:0]   end_r;
  logic [DIV_W-1:0]    div_r;
  logic                loop_r;
  logic [GAIN_W-1:0]   gain_r;
  logic [DIV_W-1:0]    hold_cnt;
  logic                busy_q;
  logic                done_q;
  logic [SAMP_W-1:0]   sample_q;
  logic                valid_q;
  logic [SAMP_W-1:0]   product;

  assign product = SAMP_W'(bus.rom_data) * SAMP_W'(gain_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr_q <= '0;
      start_r    <= '0;
      end_r      <= '0;
      div_r      <= '0;
      loop_r     <= 1'b0;
      gain_r     <= '0;
      hold_cnt   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      // stop overrides everything, including a coincident start
      if (bus.stop) begin
        state    <= IDLE;
        busy_q   <= 1'b0;
        sample_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              start_r    <= bus.cfg_start;
              end_r      <= bus.cfg_end;
              div_r      <= bus.cfg_div;
              loop_r     <= bus.cfg_loop;
              gain_r     <= bus.cfg_gain;
              rom_addr_q <= bus.cfg_start;
              busy_q     <= 1'b1;
              state      <= REQ;
            end
          end
          REQ: state <= LATCH;
          LATCH: begin
            sample_q <= product;
            valid_q  <= 1'b1;
            hold_cnt <= div_r;
            state    <= HOLD;
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              if (rom_addr_q != end_r) begin
                rom_addr_q <= rom_addr_q + ADDR_W'(1);
                state      <= REQ;
              end else if (loop_r) begin
                rom_addr_q <= start_r;
                state      <= REQ;
              end else begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
                state  <= IDLE;
              end
            end else begin
              hold_cnt <= hold_cnt - DIV_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;

  pdm_modulator #(
    .PDM_W (PDM_W)
  ) u_pdm (
    .clk     (clk),
    .rst_n   (rst_n),
    .pdm_in  (PDM_W'(sample_q)),
    .pdm_out (pdm_out)
  );

endmodule
